// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 256-bit line port to Data_Memory between the
// instruction refill path (port 0) and the dcache path (port 1), with a stuck-transaction flag.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 256,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_enable_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ack_o,
  output logic [DATA_W-1:0] req0_data_o,
  input  logic              req1_enable_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ack_o,
  output logic [DATA_W-1:0] req1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              busy_o,
  output logic              grant_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);
  localparam logic        TO_EN  = (TIMEOUT_CYC != 0);

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                grant_q, grant_d;
  logic                mem_enable_q, mem_enable_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                win_s;

  // Winner selection, next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    busy_d       = busy_q;
    timeout_d    = timeout_q;
    cnt_d        = cnt_q;
    win_s        = 1'b0;

    // Under contention the port that did not win last time goes first.
    if (req0_enable_i && req1_enable_i) begin
      win_s = ~last_grant_q;
    end else if (req1_enable_i) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (req0_enable_i || req1_enable_i) begin
          state_d      = ST_BUSY;
          grant_d      = win_s;
          last_grant_d = win_s;
          mem_enable_d = 1'b1;
          busy_d       = 1'b1;
          cnt_d        = 16'd0;
          mem_write_d  = win_s ? req1_write_i : req0_write_i;
          mem_addr_d   = win_s ? req1_addr_i  : req0_addr_i;
          mem_data_d   = win_s ? req1_data_i  : req0_data_i;
        end else begin
          mem_enable_d = 1'b0;
        end
      end
      ST_BUSY: begin
        if (mem_ack_i) begin
          state_d      = ST_RELEASE;
          mem_enable_d = 1'b0;
        end else begin
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end else begin
            cnt_d = cnt_q;
          end
          // Sticky: once set, only reset clears it; BUSY keeps waiting for ack.
          if (TO_EN && (cnt_d == TO_LIM)) begin
            timeout_d = 1'b1;
          end else begin
            timeout_d = timeout_q;
          end
        end
      end
      ST_RELEASE: begin
        state_d      = ST_IDLE;
        busy_d       = 1'b0;
        mem_enable_d = 1'b0;
      end
      default: begin
        state_d      = ST_IDLE;
        busy_d       = 1'b0;
        mem_enable_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_data_q   <= {DATA_W{1'b0}};
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      cnt_q        <= 16'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      cnt_q        <= cnt_d;
    end
  end

  // Ack is forwarded combinationally so requesters see zero added latency.
  assign req0_ack_o   = mem_ack_i & (state_q == ST_BUSY) & ~grant_q;
  assign req1_ack_o   = mem_ack_i & (state_q == ST_BUSY) &  grant_q;
  assign req0_data_o  = mem_data_i;
  assign req1_data_o  = mem_data_i;

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign busy_o       = busy_q;
  assign grant_o      = grant_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus hand sequences, with a
// scoreboard of expected memory transactions consumed by a behavioural memory.
module tb_mem_arbiter;

  localparam int TO = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         req0_enable_i, req0_write_i, req1_enable_i, req1_write_i;
  logic [31:0]  req0_addr_i, req1_addr_i, mem_addr_o;
  logic [255:0] req0_data_i, req1_data_i, req0_data_o, req1_data_o;
  logic [255:0] mem_data_o, mem_data_i;
  logic         req0_ack_o, req1_ack_o, mem_enable_o, mem_write_o, mem_ack_i;
  logic         busy_o, grant_o, timeout_o;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int ack_cyc = 0;
  bit exp_to = 1'b0;

  typedef struct {
    bit           port;
    logic         w;
    logic [31:0]  addr;
    logic [255:0] data;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    bit           en0, en1;
    logic         w0, w1;
    logic [31:0]  a0, a1;
    logic [255:0] d0, d1;
    int           delay;
    bit           exp_grant;
  } vec_t;
  vec_t vecs[6];

  mem_arbiter #(.ADDR_W(32), .DATA_W(256), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_enable_i(req0_enable_i), .req0_write_i(req0_write_i),
    .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i),
    .req0_ack_o(req0_ack_o), .req0_data_o(req0_data_o),
    .req1_enable_i(req1_enable_i), .req1_write_i(req1_write_i),
    .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i),
    .req1_ack_o(req1_ack_o), .req1_data_o(req1_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .busy_o(busy_o), .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [255:0] line_of(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_5A5A}};
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0b required %0b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    mem_ack_i = 1'b0;
    req0_enable_i = 1'b0; req1_enable_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    exp_to = 1'b0;
  endtask

  // Memory model: waits for a request, acks in the delay-th enabled cycle, checks against the scoreboard.
  task automatic mem_serve(input int delay, input bit drop, input bit spur, input bit gap_chk);
    sb_t e;
    bit  seen = 1'b0;
    if (sb.size() == 0) begin
      chk1("scoreboard_nonempty", 1'b0, 1'b1);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk_i); #1;
      if (mem_enable_o) seen = 1'b1;
    end
    chk1("enable_rise", seen, 1'b1);
    if (!seen) return;
    if (gap_chk) chkw("idle_gap", 256'(cyc - ack_cyc - 1), 256'd2);
    chk1("grant", grant_o, e.port);
    chk1("busy_in_busy", busy_o, 1'b1);
    chk1("mem_write", mem_write_o, e.w);
    chkw("mem_addr", 256'(mem_addr_o), 256'(e.addr));
    chkw("mem_data", mem_data_o, e.data);
    if (drop) begin
      req0_write_i = ~req0_write_i; req1_write_i = ~req1_write_i;
      req0_addr_i  = ~req0_addr_i;  req1_addr_i  = ~req1_addr_i;
      req0_data_i  = ~req0_data_i;  req1_data_i  = ~req1_data_i;
    end
    for (int j = 1; j <= delay; j++) begin
      if (j > 1) begin @(posedge clk_i); #1; end
      chk1("timeout_flag", timeout_o, exp_to | (j > TO));
      chk1("enable_hold", mem_enable_o, 1'b1);
    end
    mem_ack_i  = 1'b1;
    mem_data_i = line_of(e.addr);
    #1;
    chk1("ack0", req0_ack_o, ~e.port);
    chk1("ack1", req1_ack_o, e.port);
    chkw("rd_data", e.port ? req1_data_o : req0_data_o, line_of(e.addr));
    chk1("frozen_write", mem_write_o, e.w);
    chkw("frozen_addr", 256'(mem_addr_o), 256'(e.addr));
    chkw("frozen_data", mem_data_o, e.data);
    ack_cyc = cyc;
    exp_to = exp_to | (delay > TO);
    @(posedge clk_i); #1;
    mem_ack_i = spur;
    if (drop) begin req0_enable_i = 1'b0; req1_enable_i = 1'b0; end
    #1;
    chk1("release_ack0", req0_ack_o, 1'b0);
    chk1("release_ack1", req1_ack_o, 1'b0);
    chk1("release_enable", mem_enable_o, 1'b0);
    chk1("release_busy", busy_o, 1'b1);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    chk1("idle_busy", busy_o, 1'b0);
    chk1("idle_enable", mem_enable_o, 1'b0);
    chk1("idle_grant", grant_o, e.port);
    chk1("timeout_after", timeout_o, exp_to);
  endtask

  initial begin
    sb_t  e;
    bit   seen;
    rst_i = 1'b0;
    req0_enable_i = 1'b0; req0_write_i = 1'b0; req0_addr_i = 32'd0; req0_data_i = 256'd0;
    req1_enable_i = 1'b0; req1_write_i = 1'b0; req1_addr_i = 32'd0; req1_data_i = 256'd0;
    mem_ack_i = 1'b0; mem_data_i = 256'd0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 32'h0, 256'd0, 256'd0, 8, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_0040, 256'd0, {16{16'hECFA}}, 3, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_3000, {8{32'hDEAD_BEEF}}, 256'd7, 9, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_2100, 32'h0000_3100, 256'd5, {4{64'h0123_4567_89AB_CDEF}}, 2, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0080, 256'd0, 256'd0, 1, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFE_0000, 32'h0, 256'd0, 256'd0, 10, 1'b0};

    // Reset state.
    repeat (2) @(posedge clk_i);
    #1;
    chk1("rst_enable", mem_enable_o, 1'b0);
    chk1("rst_write", mem_write_o, 1'b0);
    chkw("rst_addr", 256'(mem_addr_o), 256'd0);
    chkw("rst_data", mem_data_o, 256'd0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_grant", grant_o, 1'b0);
    chk1("rst_timeout", timeout_o, 1'b0);
    rst_i = 1'b1;

    // Table-driven single transactions.
    for (int v = 0; v < 6; v++) begin
      req0_enable_i = vecs[v].en0; req0_write_i = vecs[v].w0;
      req0_addr_i = vecs[v].a0;    req0_data_i  = vecs[v].d0;
      req1_enable_i = vecs[v].en1; req1_write_i = vecs[v].w1;
      req1_addr_i = vecs[v].a1;    req1_data_i  = vecs[v].d1;
      e.port = vecs[v].exp_grant;
      e.w    = vecs[v].exp_grant ? vecs[v].w1 : vecs[v].w0;
      e.addr = vecs[v].exp_grant ? vecs[v].a1 : vecs[v].a0;
      e.data = vecs[v].exp_grant ? vecs[v].d1 : vecs[v].d0;
      sb.push_back(e);
      mem_serve(vecs[v].delay, 1'b1, 1'b0, 1'b0);
    end

    // Continuous contention after reset: grants 0,1,0 with 2-cycle gaps.
    do_reset();
    req0_write_i = 1'b0; req0_addr_i = 32'h0000_0A00; req0_data_i = 256'd0;
    req1_write_i = 1'b1; req1_addr_i = 32'h0000_0B00; req1_data_i = {8{32'h1111_2222}};
    req0_enable_i = 1'b1; req1_enable_i = 1'b1;
    e = '{1'b0, 1'b0, 32'h0000_0A00, 256'd0};              sb.push_back(e);
    e = '{1'b1, 1'b1, 32'h0000_0B00, {8{32'h1111_2222}}};  sb.push_back(e);
    e = '{1'b0, 1'b0, 32'h0000_0A00, 256'd0};              sb.push_back(e);
    mem_serve(2, 1'b0, 1'b0, 1'b0);
    mem_serve(2, 1'b0, 1'b0, 1'b1);
    mem_serve(3, 1'b1, 1'b0, 1'b1);

    // Memory silent well past the limit; the late ack must still complete.
    req0_enable_i = 1'b1; req0_write_i = 1'b1; req0_addr_i = 32'h0000_0C00; req0_data_i = 256'd9;
    e = '{1'b0, 1'b1, 32'h0000_0C00, 256'd9};
    sb.push_back(e);
    mem_serve(20, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a BUSY transaction.
    req1_enable_i = 1'b1; req1_write_i = 1'b1; req1_addr_i = 32'h0000_0055; req1_data_i = {16{16'hECFA}};
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk_i); #1;
      if (mem_enable_o) seen = 1'b1;
    end
    chk1("pre_reset_enable", seen, 1'b1);
    repeat (2) @(posedge clk_i);
    #3;
    mem_ack_i = 1'b1;
    rst_i = 1'b0;
    #1;
    chk1("arst_enable", mem_enable_o, 1'b0);
    chk1("arst_write", mem_write_o, 1'b0);
    chkw("arst_addr", 256'(mem_addr_o), 256'd0);
    chkw("arst_data", mem_data_o, 256'd0);
    chk1("arst_busy", busy_o, 1'b0);
    chk1("arst_grant", grant_o, 1'b0);
    chk1("arst_timeout", timeout_o, 1'b0);
    chk1("arst_ack0", req0_ack_o, 1'b0);
    chk1("arst_ack1", req1_ack_o, 1'b0);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    rst_i = 1'b1;
    exp_to = 1'b0;
    req0_enable_i = 1'b1; req0_write_i = 1'b0; req0_addr_i = 32'h0000_0D00;
    e = '{1'b0, 1'b0, 32'h0000_0D00, req0_data_i};
    sb.push_back(e);
    mem_serve(2, 1'b1, 1'b1, 1'b0);

    // Spurious ack while IDLE.
    mem_ack_i = 1'b1;
    #1;
    chk1("idle_spur_ack0", req0_ack_o, 1'b0);
    chk1("idle_spur_ack1", req1_ack_o, 1'b0);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    chk1("idle_spur_busy", busy_o, 1'b0);
    chk1("idle_spur_enable", mem_enable_o, 1'b0);
    chk1("idle_spur_grant", grant_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single off-chip `Data_Memory` line port (256-bit, enable/ack handshake) between the instruction-fetch refill path (port 0) and the `dcache` refill/write-back path (port 1). It sits between the cache controllers and `Data_Memory` inside the CPU top level. It grants exactly one requester at a time with round-robin priority and holds the memory request stable until `ack`. It also detects memory transactions that never complete.

## Interface
Parameters:
- `ADDR_W`, 32: line address width.
- `DATA_W`, 256: line data width.
- `TIMEOUT_CYC`, 64: BUSY cycles without ack before `timeout_o` sets; 0 disables the check.

Ports:
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `req0_enable_i` in 1: port 0 request; held high until `req0_ack_o`.
- `req0_write_i` in 1: port 0 write (1) or read (0).
- `req0_addr_i` in ADDR_W: port 0 line address.
- `req0_data_i` in DATA_W: port 0 write line.
- `req0_ack_o` out 1: one-cycle completion pulse to port 0.
- `req0_data_o` out DATA_W: read line to port 0.
- `req1_*`: identical set for port 1 (dcache).
- `mem_enable_o` out 1: request to `Data_Memory`.
- `mem_write_o` out 1: write strobe to `Data_Memory`.
- `mem_addr_o` out ADDR_W: address to `Data_Memory`.
- `mem_data_o` out DATA_W: write data to `Data_Memory`.
- `mem_ack_i` in 1: one-cycle completion pulse from `Data_Memory`.
- `mem_data_i` in DATA_W: read line from `Data_Memory`.
- `busy_o` out 1: high in BUSY and RELEASE.
- `grant_o` out 1: port index of the current or last grant.
- `timeout_o` out 1: sticky timeout flag.

## Operation
- FSM states are IDLE, BUSY and RELEASE.
- **IDLE:** `mem_enable_o` is 0.
  - On a clock edge with any `reqN_enable_i` high, the arbiter selects the winner and moves to BUSY.
  - It registers the winner's write, addr and data into `mem_write_o`, `mem_addr_o` and `mem_data_o`, sets `mem_enable_o` to 1, and sets `grant_o` to the winner.
- **Winner selection:**
  - With one requester, that requester wins.
  - With both requesting, the port opposite `last_grant` wins, then `last_grant` updates to the winner.
- **BUSY:**
  - `mem_*` outputs stay frozen; requester input changes are ignored.
  - `reqN_ack_o` = `mem_ack_i` & (state==BUSY) & (`grant_o`==N). This path is combinational.
  - `req0_data_o` and `req1_data_o` both carry `mem_data_i` (broadcast). Only the acked port may consume it.
  - On `mem_ack_i`, the arbiter clears `mem_enable_o` and goes to RELEASE.
- **RELEASE:** lasts one cycle with `mem_enable_o` = 0, so the acked requester can drop its enable. It always moves to IDLE. A `mem_ack_i` arriving in RELEASE or IDLE is ignored and produces no `reqN_ack_o`.
- **Requester drops enable during BUSY:** this is a protocol violation. The memory transaction still completes and the ack pulse is still issued.
- **Timeout counter:**
  - 16-bit counter, cleared on entry to BUSY, incremented each BUSY cycle, saturating at 0xFFFF.
  - When the count reaches `TIMEOUT_CYC` (≠0), `timeout_o` sets and stays set until reset.
  - BUSY continues waiting for ack after a timeout.
- **Reset (`rst_i` = 0, any time, including mid-transaction):**
  - State goes to IDLE and `last_grant` to 1, so port 0 wins the first contention.
  - Counter resets to 0.
  - `mem_enable_o`, `mem_write_o`, `busy_o`, `grant_o` and `timeout_o` go to 0.
  - `mem_addr_o` and `mem_data_o` go to 0.
  - `reqN_ack_o` is 0.
  - An in-flight transaction is abandoned with no ack.

## Timing
- A request first seen high in IDLE at edge k gives `mem_enable_o` = 1 from k+1.
- An ack received at cycle m gives `reqN_ack_o` in the same cycle m (zero added latency), RELEASE in cycle m+1, and IDLE in cycle m+2.
- A next grant can occur at the end of cycle m+2, with `mem_enable_o` high at m+3.
- Minimum gap between two memory transactions is 2 cycles with `mem_enable_o` low.
- Per-transaction overhead versus direct connection: +1 cycle before the request and +2 cycles after the ack.
- The timeout flag rises on the edge where the counter reaches `TIMEOUT_CYC`, i.e. after `TIMEOUT_CYC` full BUSY cycles with no ack.

## Test plan
- **Port 0 read, memory ack 10 cycles after enable:**
  - Request at edge 0; `mem_enable_o` high cycles 1..10 with `mem_write_o` = 0 and addr passed through.
  - `req0_ack_o` pulses at cycle 10 with `req0_data_o` = memory line.
  - `req1_ack_o` stays 0.
- **Both ports request at the same edge after reset, held continuously:**
  - Grants alternate 0, 1, 0.
  - Each `mem_enable_o` low gap is exactly 2 cycles.
- **Port 1 write of line 0xECFA…ECFA to addr 0x40:**
  - `mem_write_o` = 1, `mem_data_o` matches the line.
  - Changing `req1_data_i` during BUSY does not alter `mem_data_o`.
- **`TIMEOUT_CYC` = 8, memory never acks:**
  - `timeout_o` rises after 8 BUSY cycles and stays high.
  - A later ack still produces `reqN_ack_o`.
- **`rst_i` low for 1 cycle mid-BUSY:**
  - All outputs 0 immediately, asynchronously.
  - After release, a contending request is granted to port 0.
- **Spurious `mem_ack_i` in RELEASE or IDLE:** no `reqN_ack_o` and no state change.
